// File: rtl/mod_serial_checker_if.sv
// Operand/result bundle for the bit-serial residue checker.
// master drives start/A and receives status; slave is the checker.
interface mod_serial_checker_if #(
    parameter int WIDTH = 8,
    parameter int MOD   = 3
);
    logic                     start;
    logic [WIDTH-1:0]         A;
    logic                     busy;
    logic                     done;
    logic [$clog2(MOD)-1:0]   residue;
    logic                     Z_out;

    modport master (
        output start,
        output A,
        input  busy,
        input  done,
        input  residue,
        input  Z_out
    );

    modport slave (
        input  start,
        input  A,
        output busy,
        output done,
        output residue,
        output Z_out
    );
endinterface

// File: rtl/mod_serial_checker.sv
// Bit-serial A mod MOD checker, LSB first, one operand bit per clock.
// Latency: done pulses WIDTH cycles after the accepting edge; one operand per WIDTH+1 cycles.
// Backpressure: start is only honoured in IDLE/DONE; start during RUN is dropped.
module mod_serial_checker #(
    parameter int WIDTH = 8,
    parameter int MOD   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_serial_checker_if.slave  bus
);
    localparam int RW = $clog2(MOD);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [RW:0]   MODX = (RW + 1)'(MOD);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [RW-1:0]    r;
    logic [RW-1:0]    w;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [RW-1:0]    res_q;
    logic             z_q;

    logic [RW:0]      r_sum;
    logic [RW:0]      w_dbl;
    logic [RW-1:0]    r_next;
    logic [RW-1:0]    w_next;

    // r and w are both < MOD, so each sum is < 2*MOD and one subtract suffices.
    always_comb begin
        r_sum  = {1'b0, r} + (shreg[0] ? {1'b0, w} : '0);
        w_dbl  = {w, 1'b0};
        r_next = (r_sum >= MODX) ? RW'(r_sum - MODX) : RW'(r_sum);
        w_next = (w_dbl >= MODX) ? RW'(w_dbl - MODX) : RW'(w_dbl);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            r      <= '0;
            w      <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        shreg  <= bus.A;
                        r      <= '0;
                        w      <= RW'(1);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    r     <= r_next;
                    w     <= w_next;
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        res_q  <= r_next;
                        z_q    <= (r_next == '0);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.residue = res_q;
    assign bus.Z_out   = z_q;
endmodule

// File: tb/tb_mod_serial_checker.sv
// Directed bench for mod_serial_checker across several WIDTH/MOD instances.
module tb_mod_serial_checker;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   overlap83 = 0;
    int   dones66   = 0;

    logic       s6;
    logic [5:0] a6;

    mod_serial_checker_if #(.WIDTH(8),  .MOD(3)) i83 ();
    mod_serial_checker_if #(.WIDTH(8),  .MOD(5)) i85 ();
    mod_serial_checker_if #(.WIDTH(16), .MOD(7)) i167 ();
    mod_serial_checker_if #(.WIDTH(1),  .MOD(3)) i13 ();
    mod_serial_checker_if #(.WIDTH(6),  .MOD(2)) i62 ();
    mod_serial_checker_if #(.WIDTH(6),  .MOD(3)) i63 ();
    mod_serial_checker_if #(.WIDTH(6),  .MOD(5)) i65 ();
    mod_serial_checker_if #(.WIDTH(6),  .MOD(6)) i66 ();

    mod_serial_checker #(.WIDTH(8),  .MOD(3)) u83  (.clk(clk), .rst(rst), .bus(i83));
    mod_serial_checker #(.WIDTH(8),  .MOD(5)) u85  (.clk(clk), .rst(rst), .bus(i85));
    mod_serial_checker #(.WIDTH(16), .MOD(7)) u167 (.clk(clk), .rst(rst), .bus(i167));
    mod_serial_checker #(.WIDTH(1),  .MOD(3)) u13  (.clk(clk), .rst(rst), .bus(i13));
    mod_serial_checker #(.WIDTH(6),  .MOD(2)) u62  (.clk(clk), .rst(rst), .bus(i62));
    mod_serial_checker #(.WIDTH(6),  .MOD(3)) u63  (.clk(clk), .rst(rst), .bus(i63));
    mod_serial_checker #(.WIDTH(6),  .MOD(5)) u65  (.clk(clk), .rst(rst), .bus(i65));
    mod_serial_checker #(.WIDTH(6),  .MOD(6)) u66  (.clk(clk), .rst(rst), .bus(i66));

    assign i62.start = s6;  assign i62.A = a6;
    assign i63.start = s6;  assign i63.A = a6;
    assign i65.start = s6;  assign i65.A = a6;
    assign i66.start = s6;  assign i66.A = a6;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i83.busy && i83.done) overlap83++;
        if (i66.done) dones66++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one operand on the 8/3 instance and observe it; caller sits #1 after a posedge.
    task automatic run83(input logic [7:0] a, output int lat, output int busy_n,
                         output logic [1:0] res, output logic z);
        i83.A = a;
        i83.start = 1'b1;
        @(posedge clk); #1;
        i83.start = 1'b0;
        lat = -1;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (i83.done) begin lat = k; break; end
            if (i83.busy) busy_n++;
            @(posedge clk); #1;
        end
        res = i83.residue;
        z   = i83.Z_out;
    endtask

    task automatic test_reset;
        #12;
        total++; if (i83.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", i83.busy); end
        total++; if (i83.done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", i83.done); end
        total++; if (i83.residue !== 2'd0) begin bad++; $display("FAIL rst_residue: got %0d want 0", i83.residue); end
        total++; if (i83.Z_out !== 1'b0)   begin bad++; $display("FAIL rst_z: got %b want 0", i83.Z_out); end
        total++; if (i167.residue !== 3'd0) begin bad++; $display("FAIL rst_residue167: got %0d want 0", i167.residue); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (i83.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", i83.busy); end
    endtask

    task automatic test_basic;
        int lat, bn; logic [1:0] res; logic z;
        logic [7:0] ops  [4] = '{8'd12, 8'd13, 8'd255, 8'd0};
        logic [1:0] eres [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
        logic       ez   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run83(ops[i], lat, bn, res, z);
            total++; if (lat !== 8)      begin bad++; $display("FAIL basic_lat[%0d]: got %0d want 8", i, lat); end
            total++; if (bn !== 8)       begin bad++; $display("FAIL basic_busy[%0d]: got %0d want 8", i, bn); end
            total++; if (res !== eres[i]) begin bad++; $display("FAIL basic_res[%0d]: got %0d want %0d", i, res, eres[i]); end
            total++; if (z !== ez[i])    begin bad++; $display("FAIL basic_z[%0d]: got %b want %b", i, z, ez[i]); end
            @(posedge clk); #1;
            total++; if (i83.done !== 1'b0) begin bad++; $display("FAIL basic_pulse[%0d]: got %b want 0", i, i83.done); end
            if (i == 1) begin
                repeat (3) @(posedge clk);
                #1;
                total++; if (i83.residue !== 2'd1) begin bad++; $display("FAIL basic_hold: got %0d want 1", i83.residue); end
            end
        end
    endtask

    task automatic test_mod5;
        int lat = -1;
        i85.A = 8'd199; i85.start = 1'b1;
        @(posedge clk); #1;
        i85.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (i85.done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        total++; if (lat !== 8)            begin bad++; $display("FAIL mod5_lat: got %0d want 8", lat); end
        total++; if (i85.residue !== 3'd4) begin bad++; $display("FAIL mod5_res: got %0d want 4", i85.residue); end
        total++; if (i85.Z_out !== 1'b0)   begin bad++; $display("FAIL mod5_z: got %b want 0", i85.Z_out); end
    endtask

    task automatic test_mod7_w16;
        int lat = -1;
        i167.A = 16'd1000; i167.start = 1'b1;
        @(posedge clk); #1;
        i167.start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (i167.done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        total++; if (lat !== 16)            begin bad++; $display("FAIL mod7_lat: got %0d want 16", lat); end
        total++; if (i167.residue !== 3'd6) begin bad++; $display("FAIL mod7_res: got %0d want 6", i167.residue); end
        total++; if (i167.Z_out !== 1'b0)   begin bad++; $display("FAIL mod7_z: got %b want 0", i167.Z_out); end
    endtask

    task automatic test_width1;
        logic [0:0] ops  [2] = '{1'b1, 1'b0};
        logic [1:0] eres [2] = '{2'd1, 2'd0};
        for (int i = 0; i < 2; i++) begin
            i13.A = ops[i]; i13.start = 1'b1;
            @(posedge clk); #1;
            i13.start = 1'b0;
            total++; if (i13.busy !== 1'b1 || i13.done !== 1'b0)
                begin bad++; $display("FAIL w1_run[%0d]: got busy=%b done=%b want 1/0", i, i13.busy, i13.done); end
            @(posedge clk); #1;
            total++; if (i13.done !== 1'b1 || i13.busy !== 1'b0)
                begin bad++; $display("FAIL w1_done[%0d]: got done=%b busy=%b want 1/0", i, i13.done, i13.busy); end
            total++; if (i13.residue !== eres[i]) begin bad++; $display("FAIL w1_res[%0d]: got %0d want %0d", i, i13.residue, eres[i]); end
            total++; if (i13.Z_out !== (eres[i] == 2'd0)) begin bad++; $display("FAIL w1_z[%0d]: got %b", i, i13.Z_out); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_held;
        int lat1 = -1;
        int lat2 = -1;
        int nd = 0;
        i83.A = 8'd12; i83.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) i83.A = 8'd13;
            if (i83.done) begin nd++; lat1 = k; break; end
            @(posedge clk); #1;
        end
        total++; if (lat1 !== 8 || nd !== 1) begin bad++; $display("FAIL held_lat1: got %0d dones=%0d want 8/1", lat1, nd); end
        total++; if (i83.residue !== 2'd0)   begin bad++; $display("FAIL held_res1: got %0d want 0", i83.residue); end
        total++; if (i83.Z_out !== 1'b1)     begin bad++; $display("FAIL held_z1: got %b want 1", i83.Z_out); end
        @(posedge clk); #1;
        i83.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (i83.done) begin lat2 = k; break; end
            @(posedge clk); #1;
        end
        total++; if (lat2 !== 8)           begin bad++; $display("FAIL held_lat2: got %0d want 8", lat2); end
        total++; if (i83.residue !== 2'd1) begin bad++; $display("FAIL held_res2: got %0d want 1", i83.residue); end
        total++; if (i83.Z_out !== 1'b0)   begin bad++; $display("FAIL held_z2: got %b want 0", i83.Z_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        int lat, bn, nd; logic [1:0] res; logic z;
        i83.A = 8'd200; i83.start = 1'b1;
        @(posedge clk); #1;
        i83.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        total++; if (i83.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", i83.busy); end
        rst = 1'b1;
        #1;
        total++; if (i83.busy !== 1'b0)    begin bad++; $display("FAIL mid_busy: got %b want 0", i83.busy); end
        total++; if (i83.done !== 1'b0)    begin bad++; $display("FAIL mid_done: got %b want 0", i83.done); end
        total++; if (i83.residue !== 2'd0) begin bad++; $display("FAIL mid_res: got %0d want 0", i83.residue); end
        total++; if (i83.Z_out !== 1'b0)   begin bad++; $display("FAIL mid_z: got %b want 0", i83.Z_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (i83.done || i83.busy) nd++;
            @(posedge clk); #1;
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", nd); end
        run83(8'd9, lat, bn, res, z);
        total++; if (lat !== 8)    begin bad++; $display("FAIL mid_lat9: got %0d want 8", lat); end
        total++; if (res !== 2'd0) begin bad++; $display("FAIL mid_res9: got %0d want 0", res); end
        total++; if (z !== 1'b1)   begin bad++; $display("FAIL mid_z9: got %b want 1", z); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int d0;
        int k;
        d0 = dones66;
        a6 = 6'd0; s6 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            k = 0;
            while (!i66.done && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            if (k >= 20) begin total++; bad++; $display("FAIL b2b_timeout: op %0d got no done", i); end
            total++; if (k !== 6) begin bad++; $display("FAIL b2b_lat[%0d]: got %0d want 6", i, k); end
            total++; if (int'(i62.residue) !== i % 2) begin bad++; $display("FAIL b2b_m2[%0d]: got %0d want %0d", i, i62.residue, i % 2); end
            total++; if (int'(i63.residue) !== i % 3) begin bad++; $display("FAIL b2b_m3[%0d]: got %0d want %0d", i, i63.residue, i % 3); end
            total++; if (int'(i65.residue) !== i % 5) begin bad++; $display("FAIL b2b_m5[%0d]: got %0d want %0d", i, i65.residue, i % 5); end
            total++; if (int'(i66.residue) !== i % 6) begin bad++; $display("FAIL b2b_m6[%0d]: got %0d want %0d", i, i66.residue, i % 6); end
            total++; if (i63.Z_out !== (i % 3 == 0)) begin bad++; $display("FAIL b2b_z3[%0d]: got %b want %b", i, i63.Z_out, (i % 3 == 0)); end
            total++; if (i65.Z_out !== (i % 5 == 0)) begin bad++; $display("FAIL b2b_z5[%0d]: got %b want %b", i, i65.Z_out, (i % 5 == 0)); end
            if (i < 63) a6 = 6'(i + 1);
            else        s6 = 1'b0;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (dones66 - d0 !== 64) begin bad++; $display("FAIL b2b_done_count: got %0d want 64", dones66 - d0); end
    endtask

    initial begin
        rst = 1'b1;
        s6 = 1'b0; a6 = '0;
        i83.start = 1'b0;  i83.A = '0;
        i85.start = 1'b0;  i85.A = '0;
        i167.start = 1'b0; i167.A = '0;
        i13.start = 1'b0;  i13.A = '0;
        test_reset();
        test_basic();
        test_mod5();
        test_mod7_w16();
        test_width1();
        test_start_held();
        test_reset_midrun();
        test_back_to_back();
        total++; if (overlap83 !== 0) begin bad++; $display("FAIL busy_done_overlap: got %0d want 0", overlap83); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
